// File: rtl/vigenere_stream_ctrl_if.sv
// Bundles the key-load, ciphertext, core and plaintext signals of the
// Vigenere stream controller. The slave modport is the controller's view;
// the master modport is the view of whatever surrounds it (the key/message
// source, the decryption core and the plaintext sink).
interface vigenere_stream_ctrl_if;
    logic       key_clear;
    logic       key_wr_valid;
    logic [7:0] key_wr_char;
    logic       key_wr_last;
    logic       msg_restart;
    logic       ctxt_in_valid;
    logic [7:0] ctxt_in_char;
    logic       ctxt_in_ready;
    logic [7:0] core_ctx_char;
    logic [7:0] core_key_char;
    logic       core_ctxt_valid;
    logic [7:0] core_ptxt_char;
    logic       core_ptxt_ready;
    logic       ptxt_out_valid;
    logic [7:0] ptxt_out_char;
    logic       key_loaded;
    logic       key_err;

    modport slave (
        input  key_clear, key_wr_valid, key_wr_char, key_wr_last, msg_restart,
        input  ctxt_in_valid, ctxt_in_char, core_ptxt_char, core_ptxt_ready,
        output ctxt_in_ready, core_ctx_char, core_key_char, core_ctxt_valid,
        output ptxt_out_valid, ptxt_out_char, key_loaded, key_err
    );

    modport master (
        output key_clear, key_wr_valid, key_wr_char, key_wr_last, msg_restart,
        output ctxt_in_valid, ctxt_in_char, core_ptxt_char, core_ptxt_ready,
        input  ctxt_in_ready, core_ctx_char, core_key_char, core_ctxt_valid,
        input  ptxt_out_valid, ptxt_out_char, key_loaded, key_err
    );
endinterface

// File: rtl/vigenere_stream_ctrl.sv
// Vigenere stream sequencer: owns the key buffer, feeds the 1-cycle
// vigenere_cipher_dec core one ciphertext/key pair per cycle, and routes
// non-letter ciphertext around the core so it emerges in order at the same
// latency as decrypted letters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// EMPTY   | no key held, waiting for the first key character
// LOAD    | key partially written, waiting for more characters / last
// RUN     | key complete, ciphertext accepted one character per cycle
// KERR    | bad key character or overflow, waits for key_clear / rst
module vigenere_stream_ctrl #(
    parameter int MAX_KEY_LEN = 32,
    parameter int IDX_W       = 5
) (
    input logic                   clk,
    input logic                   rst,
    vigenere_stream_ctrl_if.slave bus
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_KERR  = 2'd3;

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MAX_KEY_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   LEN_ONE = (IDX_W + 1)'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       key_buf [MAX_KEY_LEN];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W:0]   key_len;
    logic [IDX_W-1:0] key_idx;
    logic [IDX_W-1:0] idx_sel;
    logic [IDX_W-1:0] idx_nxt;
    logic             idx_wrap;

    logic             loading;
    logic             key_is_letter;
    logic             ctxt_is_letter;
    logic             key_wr_en;
    logic             accept;

    // Stage 1 (core input side) and stage 2 (aligned with core output)
    logic [7:0]       core_ctx_q;
    logic [7:0]       core_key_q;
    logic             core_valid_q;
    logic             v1;
    logic             byp1;
    logic [7:0]       bypchar1;
    logic             v2;
    logic             byp2;
    logic [7:0]       bypchar2;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    assign loading        = (state == S_EMPTY) || (state == S_LOAD);
    assign key_is_letter  = is_letter(bus.key_wr_char);
    assign ctxt_is_letter = is_letter(bus.ctxt_in_char);

    // A key character is stored only if it is a letter and, when it lands in
    // the final slot, it is also marked last; anything else trips KERR.
    assign key_wr_en = !bus.key_clear && loading && bus.key_wr_valid && key_is_letter
                       && !((wr_ptr == IDX_TOP) && !bus.key_wr_last);

    assign bus.ctxt_in_ready = (state == S_RUN) && !bus.key_clear;
    assign accept            = bus.ctxt_in_valid && bus.ctxt_in_ready;

    // msg_restart on the accepting cycle makes this character use index 0.
    assign idx_sel  = bus.msg_restart ? '0 : key_idx;
    assign idx_wrap = ({1'b0, idx_sel} == (key_len - LEN_ONE));
    assign idx_nxt  = idx_wrap ? '0 : (idx_sel + IDX_ONE);

    // Next-state decode; key_clear overrides everything.
    always_comb begin
        state_nxt = state;
        if (bus.key_clear) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY, S_LOAD: begin
                    if (bus.key_wr_valid) begin
                        if (!key_wr_en)           state_nxt = S_KERR;
                        else if (bus.key_wr_last) state_nxt = S_RUN;
                        else                      state_nxt = S_LOAD;
                    end
                end
                S_RUN:   state_nxt = S_RUN;
                default: state_nxt = S_KERR;
            endcase
        end
    end

    // FSM state, key write pointer and captured key length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_EMPTY;
            wr_ptr  <= '0;
            key_len <= '0;
        end else begin
            state <= state_nxt;
            if (bus.key_clear) begin
                wr_ptr  <= '0;
                key_len <= '0;
            end else if (key_wr_en) begin
                wr_ptr <= wr_ptr + IDX_ONE;
                if (bus.key_wr_last) begin
                    key_len <= {1'b0, wr_ptr} + LEN_ONE;
                end
            end
        end
    end

    // Key storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (key_wr_en) begin
            key_buf[wr_ptr] <= bus.key_wr_char;
        end
    end

    // Key index: advances only on accepted letters and wraps at key_len.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_idx <= '0;
        end else if (bus.key_clear) begin
            key_idx <= '0;
        end else if (key_wr_en && bus.key_wr_last) begin
            key_idx <= '0;
        end else if (accept && ctxt_is_letter) begin
            key_idx <= idx_nxt;
        end else if (bus.msg_restart) begin
            key_idx <= '0;
        end
    end

    // Stage 1: present letters to the core, capture non-letters for bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ctx_q   <= '0;
            core_key_q   <= '0;
            core_valid_q <= 1'b0;
            v1           <= 1'b0;
            byp1         <= 1'b0;
            bypchar1     <= '0;
        end else if (accept) begin
            v1 <= 1'b1;
            if (ctxt_is_letter) begin
                core_ctx_q   <= bus.ctxt_in_char;
                core_key_q   <= key_buf[idx_sel];
                core_valid_q <= 1'b1;
                byp1         <= 1'b0;
            end else begin
                core_ctx_q   <= '0;
                core_key_q   <= '0;
                core_valid_q <= 1'b0;
                byp1         <= 1'b1;
                bypchar1     <= bus.ctxt_in_char;
            end
        end else begin
            core_ctx_q   <= '0;
            core_key_q   <= '0;
            core_valid_q <= 1'b0;
            v1           <= 1'b0;
        end
    end

    // Stage 2: tags travel alongside the core's own output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            byp2     <= 1'b0;
            bypchar2 <= '0;
        end else begin
            v2       <= v1;
            byp2     <= byp1;
            bypchar2 <= bypchar1;
        end
    end

    // Output mux: bypass char, core result, or '?' if the core had nothing.
    always_comb begin
        bus.ptxt_out_valid = v2;
        bus.ptxt_out_char  = 8'h00;
        if (byp2) begin
            bus.ptxt_out_char = bypchar2;
        end else if (bus.core_ptxt_ready) begin
            bus.ptxt_out_char = bus.core_ptxt_char;
        end else begin
            bus.ptxt_out_char = 8'h3F;
        end
    end

    assign bus.core_ctx_char   = core_ctx_q;
    assign bus.core_key_char   = core_key_q;
    assign bus.core_ctxt_valid = core_valid_q;
    assign bus.key_loaded      = (state == S_RUN);
    assign bus.key_err         = (state == S_KERR);

endmodule

// File: tb/tb_vigenere_stream_ctrl.sv
// Directed bench for vigenere_stream_ctrl with a behavioural 1-cycle
// decryption core model attached to the core_* signals.
module tb_vigenere_stream_ctrl;

    logic clk;
    logic rst;
    logic force_nready;
    int   checks;
    int   failures;

    logic [7:0] got_q[$];
    int         first_cyc;
    int         last_cyc;

    vigenere_stream_ctrl_if bus();

    vigenere_stream_ctrl #(.MAX_KEY_LEN(32), .IDX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dec(input logic [7:0] c, input logic [7:0] k);
        int d;
        d = (int'(c) - int'(k) + 26) % 26;
        return 8'(65 + d);
    endfunction

    // Behavioural decryption core: registered result, ready follows valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.core_ptxt_char  <= 8'h00;
            bus.core_ptxt_ready <= 1'b0;
        end else begin
            bus.core_ptxt_char  <= dec(bus.core_ctx_char, bus.core_key_char);
            bus.core_ptxt_ready <= bus.core_ctxt_valid && !force_nready;
        end
    end

    task automatic drive_idle();
        bus.key_clear     = 1'b0;
        bus.key_wr_valid  = 1'b0;
        bus.key_wr_char   = 8'h00;
        bus.key_wr_last   = 1'b0;
        bus.msg_restart   = 1'b0;
        bus.ctxt_in_valid = 1'b0;
        bus.ctxt_in_char  = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input string k, input bit last_on_end);
        drive_idle();
        bus.key_clear = 1'b1;
        tick();
        bus.key_clear = 1'b0;
        for (int i = 0; i < k.len(); i++) begin
            bus.key_wr_valid = 1'b1;
            bus.key_wr_char  = k[i];
            bus.key_wr_last  = last_on_end && (i == k.len() - 1);
            tick();
        end
        drive_idle();
    endtask

    task automatic run_stream(input string s, input int restart_at);
        got_q.delete();
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < s.len() + 3; c++) begin
            if (c < s.len()) begin
                bus.ctxt_in_valid = 1'b1;
                bus.ctxt_in_char  = s[c];
                bus.msg_restart   = (c == restart_at);
            end else begin
                bus.ctxt_in_valid = 1'b0;
                bus.ctxt_in_char  = 8'h00;
                bus.msg_restart   = 1'b0;
            end
            tick();
            if (bus.ptxt_out_valid === 1'b1) begin
                got_q.push_back(bus.ptxt_out_char);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.ptxt_out_valid !== 1'b0 || bus.core_ctxt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valids got out=%b core=%b exp 0", bus.ptxt_out_valid, bus.core_ctxt_valid);
        end
        checks++;
        if (bus.key_loaded !== 1'b0 || bus.key_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got loaded=%b err=%b exp 0", bus.key_loaded, bus.key_err);
        end
        checks++;
        if (bus.core_ctx_char !== 8'h00 || bus.core_key_char !== 8'h00) begin
            failures++;
            $display("FAIL reset_core_chars got %h %h exp 00", bus.core_ctx_char, bus.core_key_char);
        end
        bus.ctxt_in_valid = 1'b1;
        #1;
        checks++;
        if (bus.ctxt_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got %b exp 0", bus.ctxt_in_ready);
        end
        drive_idle();
    endtask

    task automatic test_hello();
        string exp = "HELLO";
        logic [7:0] g;
        load_key("KEY", 1'b1);
        checks++;
        if (bus.key_loaded !== 1'b1 || bus.ctxt_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hello_loaded got loaded=%b ready=%b exp 1", bus.key_loaded, bus.ctxt_in_ready);
        end
        run_stream("RIJVS", -1);
        checks++;
        if (got_q.size() != exp.len()) begin
            failures++;
            $display("FAIL hello_count got %0d exp %0d", got_q.size(), exp.len());
        end
        for (int i = 0; i < exp.len(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL hello_char[%0d] got %h exp %h", i, g, exp[i]);
            end
        end
        checks++;
        if (first_cyc != 1 || last_cyc != 5) begin
            failures++;
            $display("FAIL hello_timing got first=%0d last=%0d exp 1 5", first_cyc, last_cyc);
        end
    endtask

    task automatic test_bypass();
        string exp = "HEL LO!";
        logic [7:0] g;
        load_key("KEY", 1'b1);
        run_stream("RIJ VS!", -1);
        checks++;
        if (got_q.size() != exp.len() || first_cyc != 1 || last_cyc != 7) begin
            failures++;
            $display("FAIL bypass_count got n=%0d first=%0d last=%0d exp 7 1 7", got_q.size(), first_cyc, last_cyc);
        end
        for (int i = 0; i < exp.len(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL bypass_char[%0d] got %h exp %h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_restart();
        string exp = "HEHE";
        logic [7:0] g;
        load_key("KEY", 1'b1);
        run_stream("RIRI", 2);
        checks++;
        if (got_q.size() != exp.len()) begin
            failures++;
            $display("FAIL restart_count got %0d exp %0d", got_q.size(), exp.len());
        end
        for (int i = 0; i < exp.len(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL restart_char[%0d] got %h exp %h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_key_err();
        string exp = "BB";
        logic [7:0] g;
        load_key("AB", 1'b0);
        checks++;
        if (bus.key_err !== 1'b0 || bus.key_loaded !== 1'b0) begin
            failures++;
            $display("FAIL kerr_partial got err=%b loaded=%b exp 0 0", bus.key_err, bus.key_loaded);
        end
        bus.key_wr_valid = 1'b1;
        bus.key_wr_char  = 8'h61;
        tick();
        drive_idle();
        bus.ctxt_in_valid = 1'b1;
        bus.ctxt_in_char  = 8'h52;
        #1;
        checks++;
        if (bus.key_err !== 1'b1 || bus.ctxt_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL kerr_enter got err=%b ready=%b exp 1 0", bus.key_err, bus.ctxt_in_ready);
        end
        tick();
        checks++;
        if (bus.key_err !== 1'b1 || bus.core_ctxt_valid !== 1'b0) begin
            failures++;
            $display("FAIL kerr_hold got err=%b core_valid=%b exp 1 0", bus.key_err, bus.core_ctxt_valid);
        end
        drive_idle();
        bus.key_clear = 1'b1;
        tick();
        drive_idle();
        checks++;
        if (bus.key_err !== 1'b0 || bus.key_loaded !== 1'b0) begin
            failures++;
            $display("FAIL kerr_clear got err=%b loaded=%b exp 0 0", bus.key_err, bus.key_loaded);
        end
        load_key("B", 1'b1);
        run_stream("CC", -1);
        checks++;
        if (got_q.size() != exp.len()) begin
            failures++;
            $display("FAIL keylen1_count got %0d exp %0d", got_q.size(), exp.len());
        end
        for (int i = 0; i < exp.len(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL keylen1_char[%0d] got %h exp %h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        string k = "B";
        string s = "";
        logic [7:0] g;
        logic [7:0] e;
        drive_idle();
        bus.key_clear = 1'b1;
        tick();
        bus.key_clear = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.key_wr_valid = 1'b1;
            bus.key_wr_char  = 8'h41;
            bus.key_wr_last  = 1'b0;
            tick();
            if (i == 30) begin
                checks++;
                if (bus.key_err !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_31 got err=%b exp 0", bus.key_err);
                end
            end
        end
        drive_idle();
        checks++;
        if (bus.key_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_32 got err=%b exp 1", bus.key_err);
        end
        for (int i = 1; i < 32; i++) k = {k, "A"};
        for (int i = 0; i < 33; i++) s = {s, "C"};
        load_key(k, 1'b1);
        checks++;
        if (bus.key_loaded !== 1'b1) begin
            failures++;
            $display("FAIL full_key_loaded got %b exp 1", bus.key_loaded);
        end
        run_stream(s, -1);
        checks++;
        if (got_q.size() != 33) begin
            failures++;
            $display("FAIL full_key_count got %0d exp 33", got_q.size());
        end
        for (int i = 0; i < 33; i++) begin
            if (i == 0 || i == 1 || i == 31 || i == 32) begin
                g = (i < got_q.size()) ? got_q[i] : 8'h00;
                e = ((i % 32) == 0) ? 8'h42 : 8'h43;
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL full_key_char[%0d] got %h exp %h", i, g, e);
                end
            end
        end
    endtask

    task automatic test_core_not_ready();
        string exp = "? ?";
        logic [7:0] g;
        load_key("KEY", 1'b1);
        force_nready = 1'b1;
        run_stream("R S", -1);
        force_nready = 1'b0;
        checks++;
        if (got_q.size() != exp.len()) begin
            failures++;
            $display("FAIL nready_count got %0d exp %0d", got_q.size(), exp.len());
        end
        for (int i = 0; i < exp.len(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL nready_char[%0d] got %h exp %h", i, g, exp[i]);
            end
        end
    endtask

    task automatic test_clear_inflight();
        load_key("KEY", 1'b1);
        bus.ctxt_in_valid = 1'b1;
        bus.ctxt_in_char  = 8'h52;
        tick();
        bus.ctxt_in_char  = 8'h49;
        tick();
        checks++;
        if (bus.ptxt_out_valid !== 1'b1 || bus.ptxt_out_char !== 8'h48) begin
            failures++;
            $display("FAIL clr_first got v=%b c=%h exp 1 48", bus.ptxt_out_valid, bus.ptxt_out_char);
        end
        bus.ctxt_in_char = 8'h4A;
        bus.key_clear    = 1'b1;
        #1;
        checks++;
        if (bus.ctxt_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_ready got %b exp 0", bus.ctxt_in_ready);
        end
        tick();
        drive_idle();
        checks++;
        if (bus.ptxt_out_valid !== 1'b1 || bus.ptxt_out_char !== 8'h45 || bus.key_loaded !== 1'b0) begin
            failures++;
            $display("FAIL clr_second got v=%b c=%h loaded=%b exp 1 45 0",
                     bus.ptxt_out_valid, bus.ptxt_out_char, bus.key_loaded);
        end
        tick();
        checks++;
        if (bus.ptxt_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_drained got v=%b exp 0", bus.ptxt_out_valid);
        end
    endtask

    task automatic test_rst_midstream();
        int stray;
        string exp = "HELLO";
        logic [7:0] g;
        load_key("KEY", 1'b1);
        bus.ctxt_in_valid = 1'b1;
        bus.ctxt_in_char  = 8'h52;
        tick();
        bus.ctxt_in_char  = 8'h49;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ptxt_out_valid !== 1'b0 || bus.core_ctxt_valid !== 1'b0 || bus.core_ctx_char !== 8'h00
            || bus.core_key_char !== 8'h00) begin
            failures++;
            $display("FAIL rst_outputs got v=%b cv=%b ctx=%h key=%h exp 0 0 00 00",
                     bus.ptxt_out_valid, bus.core_ctxt_valid, bus.core_ctx_char, bus.core_key_char);
        end
        checks++;
        if (bus.key_loaded !== 1'b0 || bus.ctxt_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_state got loaded=%b ready=%b exp 0 0", bus.key_loaded, bus.ctxt_in_ready);
        end
        tick();
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ptxt_out_valid !== 1'b0 || bus.ctxt_in_ready !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_no_output got %0d busy cycles exp 0", stray);
        end
        drive_idle();
        load_key("KEY", 1'b1);
        run_stream("RIJVS", -1);
        checks++;
        if (got_q.size() != exp.len()) begin
            failures++;
            $display("FAIL rst_reload_count got %0d exp %0d", got_q.size(), exp.len());
        end
        for (int i = 0; i < exp.len(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            checks++;
            if (g !== exp[i]) begin
                failures++;
                $display("FAIL rst_reload_char[%0d] got %h exp %h", i, g, exp[i]);
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        force_nready = 1'b0;
        drive_idle();
        rst = 1'b1;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        test_hello();
        test_bypass();
        test_restart();
        test_key_err();
        test_overflow();
        test_core_not_ready();
        test_clear_inflight();
        test_rst_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
